w0rm_core_operand_fetch: RTL and testbench

Register-read stage between instruction decode and the ALU. It drives both read ports of W0RM_Core_RegisterFile, which runs in single-cycle mode with combinational read data. It owns the register file write port, fed by ALU writeback. It tracks outstanding writes in a scoreboard, stalls on hazards, bypasses same-cycle writeback data, and presents operands to the ALU through a one-entry valid/ready output register.

---
 rtl/w0rm_core_pkg.sv | 25 ++
 rtl/w0rm_core_operand_fetch_if.sv | 100 ++++++++++
 rtl/w0rm_core_scoreboard.sv | 48 ++++
 rtl/w0rm_core_operand_fetch.sv | 115 +++++++++++
 tb/tb_w0rm_core_operand_fetch.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/w0rm_core_pkg.sv
// Shared widths and helpers for the W0RM core operand-fetch slice.
// Address width is derived from the register count, never passed in.
package w0rm_core_pkg;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_NUM_REGISTERS = 16;
    localparam int DEF_OPCODE_WIDTH  = 8;

    function automatic int log2_ceil(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A single register still needs a one-bit address field.
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : log2_ceil(n);
    endfunction

endpackage

// File: rtl/w0rm_core_operand_fetch_if.sv
// Bundle of decode, register-file, writeback and ALU signals of the
// operand-fetch stage; slave is the stage, master is its surroundings.
interface w0rm_core_operand_fetch_if
    import w0rm_core_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int NUM_REGISTERS = DEF_NUM_REGISTERS,
    parameter int OPCODE_WIDTH  = DEF_OPCODE_WIDTH
);
    localparam int ADDR_WIDTH = addr_width(NUM_REGISTERS);

    logic                    decode_valid;
    logic                    decode_ready;
    logic [OPCODE_WIDTH-1:0] decode_opcode;
    logic [ADDR_WIDTH-1:0]   decode_dest;
    logic                    decode_writes;
    logic [ADDR_WIDTH-1:0]   decode_src_a;
    logic [ADDR_WIDTH-1:0]   decode_src_b;
    logic                    decode_use_imm;
    logic [DATA_WIDTH-1:0]   decode_imm;

    logic [ADDR_WIDTH-1:0]   rf_read0_addr;
    logic [DATA_WIDTH-1:0]   rf_read0_data;
    logic [ADDR_WIDTH-1:0]   rf_read1_addr;
    logic [DATA_WIDTH-1:0]   rf_read1_data;
    logic [ADDR_WIDTH-1:0]   rf_write_addr;
    logic                    rf_write_enable;
    logic [DATA_WIDTH-1:0]   rf_write_data;

    logic                    wb_valid;
    logic [ADDR_WIDTH-1:0]   wb_addr;
    logic [DATA_WIDTH-1:0]   wb_data;

    logic                    alu_valid;
    logic                    alu_ready;
    logic [OPCODE_WIDTH-1:0] alu_opcode;
    logic [ADDR_WIDTH-1:0]   alu_dest;
    logic                    alu_writes;
    logic [DATA_WIDTH-1:0]   alu_data_a;
    logic [DATA_WIDTH-1:0]   alu_data_b;

    modport slave (
        input  decode_valid,
        output decode_ready,
        input  decode_opcode,
        input  decode_dest,
        input  decode_writes,
        input  decode_src_a,
        input  decode_src_b,
        input  decode_use_imm,
        input  decode_imm,
        output rf_read0_addr,
        input  rf_read0_data,
        output rf_read1_addr,
        input  rf_read1_data,
        output rf_write_addr,
        output rf_write_enable,
        output rf_write_data,
        input  wb_valid,
        input  wb_addr,
        input  wb_data,
        output alu_valid,
        input  alu_ready,
        output alu_opcode,
        output alu_dest,
        output alu_writes,
        output alu_data_a,
        output alu_data_b
    );

    modport master (
        output decode_valid,
        input  decode_ready,
        output decode_opcode,
        output decode_dest,
        output decode_writes,
        output decode_src_a,
        output decode_src_b,
        output decode_use_imm,
        output decode_imm,
        input  rf_read0_addr,
        output rf_read0_data,
        input  rf_read1_addr,
        output rf_read1_data,
        input  rf_write_addr,
        input  rf_write_enable,
        input  rf_write_data,
        output wb_valid,
        output wb_addr,
        output wb_data,
        input  alu_valid,
        output alu_ready,
        input  alu_opcode,
        input  alu_dest,
        input  alu_writes,
        input  alu_data_a,
        input  alu_data_b
    );

endinterface

// File: rtl/w0rm_core_scoreboard.sv
// One busy bit per register: set on issue of a writer, cleared on
// writeback; when both hit the same register the set wins.
module w0rm_core_scoreboard
    import w0rm_core_pkg::*;
#(
    parameter int NUM_REGISTERS = DEF_NUM_REGISTERS,
    parameter int ADDR_WIDTH    = addr_width(NUM_REGISTERS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_set,
    input  logic [ADDR_WIDTH-1:0] i_set_addr,
    input  logic                  i_clr,
    input  logic [ADDR_WIDTH-1:0] i_clr_addr,
    input  logic [ADDR_WIDTH-1:0] i_look_a,
    input  logic [ADDR_WIDTH-1:0] i_look_b,
    input  logic [ADDR_WIDTH-1:0] i_look_d,
    output logic                  o_busy_a,
    output logic                  o_busy_b,
    output logic                  o_busy_d
);

    logic [NUM_REGISTERS-1:0] r_busy;
    logic [NUM_REGISTERS-1:0] w_busy_next;

    always_comb begin
        w_busy_next = r_busy;
        if (i_clr) begin
            w_busy_next[i_clr_addr] = 1'b0;
        end
        if (i_set) begin
            w_busy_next[i_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign o_busy_a = r_busy[i_look_a];
    assign o_busy_b = r_busy[i_look_b];
    assign o_busy_d = r_busy[i_look_d];

endmodule

// File: rtl/w0rm_core_operand_fetch.sv
// Register-read stage: hazard stall, writeback bypass and a one-entry
// valid/ready operand register feeding the ALU.
module w0rm_core_operand_fetch
    import w0rm_core_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int NUM_REGISTERS = DEF_NUM_REGISTERS,
    parameter int OPCODE_WIDTH  = DEF_OPCODE_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    w0rm_core_operand_fetch_if.slave   bus
);

    localparam int ADDR_WIDTH = addr_width(NUM_REGISTERS);

    logic                    w_busy_a;
    logic                    w_busy_b;
    logic                    w_busy_d;
    logic                    w_clr_a;
    logic                    w_clr_b;
    logic                    w_clr_d;
    logic                    w_raw_a;
    logic                    w_raw_b;
    logic                    w_waw;
    logic                    w_hazard;
    logic                    w_out_free;
    logic                    w_ready;
    logic                    w_accept;
    logic [DATA_WIDTH-1:0]   w_op_a;
    logic [DATA_WIDTH-1:0]   w_op_b;

    logic                    r_alu_valid;
    logic [OPCODE_WIDTH-1:0] r_alu_opcode;
    logic [ADDR_WIDTH-1:0]   r_alu_dest;
    logic                    r_alu_writes;
    logic [DATA_WIDTH-1:0]   r_alu_data_a;
    logic [DATA_WIDTH-1:0]   r_alu_data_b;

    assign bus.rf_read0_addr   = bus.decode_src_a;
    assign bus.rf_read1_addr   = bus.decode_src_b;
    assign bus.rf_write_addr   = bus.wb_addr;
    assign bus.rf_write_enable = bus.wb_valid;
    assign bus.rf_write_data   = bus.wb_data;

    w0rm_core_scoreboard #(
        .NUM_REGISTERS (NUM_REGISTERS),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_set      (w_accept && bus.decode_writes),
        .i_set_addr (bus.decode_dest),
        .i_clr      (bus.wb_valid),
        .i_clr_addr (bus.wb_addr),
        .i_look_a   (bus.decode_src_a),
        .i_look_b   (bus.decode_src_b),
        .i_look_d   (bus.decode_dest),
        .o_busy_a   (w_busy_a),
        .o_busy_b   (w_busy_b),
        .o_busy_d   (w_busy_d)
    );

    assign w_clr_a = bus.wb_valid && (bus.wb_addr == bus.decode_src_a);
    assign w_clr_b = bus.wb_valid && (bus.wb_addr == bus.decode_src_b);
    assign w_clr_d = bus.wb_valid && (bus.wb_addr == bus.decode_dest);

    // A register being written back this cycle is already resolved.
    assign w_raw_a  = w_busy_a && !w_clr_a;
    assign w_raw_b  = !bus.decode_use_imm && w_busy_b && !w_clr_b;
    assign w_waw    = bus.decode_writes && w_busy_d && !w_clr_d;
    assign w_hazard = w_raw_a || w_raw_b || w_waw;

    assign w_out_free = !r_alu_valid || bus.alu_ready;
    assign w_ready    = !w_hazard && w_out_free;
    assign w_accept   = bus.decode_valid && w_ready;

    assign bus.decode_ready = w_ready;

    always_comb begin
        w_op_a = w_clr_a ? bus.wb_data : bus.rf_read0_data;
        w_op_b = w_clr_b ? bus.wb_data : bus.rf_read1_data;
        if (bus.decode_use_imm) begin
            w_op_b = bus.decode_imm;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alu_valid  <= 1'b0;
            r_alu_opcode <= '0;
            r_alu_dest   <= '0;
            r_alu_writes <= 1'b0;
            r_alu_data_a <= '0;
            r_alu_data_b <= '0;
        end else if (w_accept) begin
            r_alu_valid  <= 1'b1;
            r_alu_opcode <= bus.decode_opcode;
            r_alu_dest   <= bus.decode_dest;
            r_alu_writes <= bus.decode_writes;
            r_alu_data_a <= w_op_a;
            r_alu_data_b <= w_op_b;
        end else if (bus.alu_ready) begin
            r_alu_valid  <= 1'b0;
        end
    end

    assign bus.alu_valid  = r_alu_valid;
    assign bus.alu_opcode = r_alu_opcode;
    assign bus.alu_dest   = r_alu_dest;
    assign bus.alu_writes = r_alu_writes;
    assign bus.alu_data_a = r_alu_data_a;
    assign bus.alu_data_b = r_alu_data_b;

endmodule

// File: tb/tb_w0rm_core_operand_fetch.sv
// Directed bench for the operand-fetch stage with a behavioural
// register file; expected values are hand-derived per step.
module tb_w0rm_core_operand_fetch;

    logic clk;
    logic reset_n;
    int   n_assert;
    int   n_fail;

    logic [31:0] rf [16];

    w0rm_core_operand_fetch_if bus ();

    w0rm_core_operand_fetch u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.rf_read0_data = rf[bus.rf_read0_addr];
    assign bus.rf_read1_data = rf[bus.rf_read1_addr];

    always @(posedge clk) begin
        if (bus.rf_write_enable) begin
            rf[bus.rf_write_addr] <= bus.rf_write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [7:0] op,
                       input logic [3:0] d, input logic w,
                       input logic [3:0] sa, input logic [3:0] sb,
                       input logic ui, input logic [31:0] imm);
        bus.decode_valid   = v;
        bus.decode_opcode  = op;
        bus.decode_dest    = d;
        bus.decode_writes  = w;
        bus.decode_src_a   = sa;
        bus.decode_src_b   = sb;
        bus.decode_use_imm = ui;
        bus.decode_imm     = imm;
    endtask

    task automatic wb(input logic v, input logic [3:0] a,
                      input logic [31:0] d);
        bus.wb_valid = v;
        bus.wb_addr  = a;
        bus.wb_data  = d;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < 16; i++) begin
            rf[i] = 32'h100 + 32'(i);
        end
        reset_n       = 1'b0;
        bus.alu_ready = 1'b1;
        drv(1'b0, 8'h00, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 32'h0);
        wb(1'b0, 4'd0, 32'h0);
        #22;
        chk("rst_valid", 32'(bus.alu_valid), 32'd0);
        chk("rst_opcode", 32'(bus.alu_opcode), 32'd0);
        chk("rst_data_a", bus.alu_data_a, 32'd0);
        reset_n = 1'b1;
        tick();

        // back-to-back independent writers
        drv(1'b1, 8'h11, 4'd1, 1'b1, 4'd2, 4'd0, 1'b0, 32'h0);
        settle();
        chk("b2b_rdy0", 32'(bus.decode_ready), 32'd1);
        chk("rf_addr0", 32'(bus.rf_read0_addr), 32'd2);
        tick();
        chk("b2b_v0", 32'(bus.alu_valid), 32'd1);
        chk("b2b_a0", bus.alu_data_a, 32'h102);
        chk("b2b_b0", bus.alu_data_b, 32'h100);
        chk("b2b_op0", 32'(bus.alu_opcode), 32'h11);
        drv(1'b1, 8'h22, 4'd3, 1'b1, 4'd4, 4'd5, 1'b0, 32'h0);
        settle();
        chk("b2b_rdy1", 32'(bus.decode_ready), 32'd1);
        chk("rf_addr1", 32'(bus.rf_read1_addr), 32'd5);
        tick();
        chk("b2b_v1", 32'(bus.alu_valid), 32'd1);
        chk("b2b_a1", bus.alu_data_a, 32'h104);
        chk("b2b_b1", bus.alu_data_b, 32'h105);
        chk("b2b_dest1", 32'(bus.alu_dest), 32'd3);

        // RAW on r3 resolved by same-cycle writeback bypass
        drv(1'b1, 8'h33, 4'd6, 1'b1, 4'd3, 4'd0, 1'b0, 32'h0);
        settle();
        chk("raw_stall0", 32'(bus.decode_ready), 32'd0);
        tick();
        chk("raw_bubble", 32'(bus.alu_valid), 32'd0);
        chk("raw_stall1", 32'(bus.decode_ready), 32'd0);
        wb(1'b1, 4'd3, 32'h55);
        settle();
        chk("raw_rdy", 32'(bus.decode_ready), 32'd1);
        chk("rf_we", 32'(bus.rf_write_enable), 32'd1);
        chk("rf_wdata", bus.rf_write_data, 32'h55);
        tick();
        wb(1'b0, 4'd0, 32'h0);
        chk("raw_v", 32'(bus.alu_valid), 32'd1);
        chk("raw_a", bus.alu_data_a, 32'h55);
        chk("raw_dest", 32'(bus.alu_dest), 32'd6);

        // backpressure holds the output register
        bus.alu_ready = 1'b0;
        drv(1'b1, 8'h44, 4'd9, 1'b1, 4'd7, 4'd8, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_rdy", 32'(bus.decode_ready), 32'd0);
            tick();
            chk("bp_v", 32'(bus.alu_valid), 32'd1);
            chk("bp_op", 32'(bus.alu_opcode), 32'h33);
            chk("bp_a", bus.alu_data_a, 32'h55);
        end
        bus.alu_ready = 1'b1;
        settle();
        chk("bp_rel_rdy", 32'(bus.decode_ready), 32'd1);
        tick();
        chk("bp_op_new", 32'(bus.alu_opcode), 32'h44);
        chk("bp_a_new", bus.alu_data_a, 32'h107);
        chk("bp_b_new", bus.alu_data_b, 32'h108);

        // set-wins on r5 when writeback and new writer collide
        drv(1'b1, 8'h55, 4'd5, 1'b1, 4'd0, 4'd0, 1'b0, 32'h0);
        tick();
        drv(1'b1, 8'h56, 4'd5, 1'b1, 4'd0, 4'd0, 1'b0, 32'h0);
        wb(1'b1, 4'd5, 32'h77);
        settle();
        chk("sw_rdy", 32'(bus.decode_ready), 32'd1);
        tick();
        wb(1'b0, 4'd0, 32'h0);
        drv(1'b1, 8'h57, 4'd10, 1'b0, 4'd5, 4'd5, 1'b0, 32'h0);
        settle();
        chk("sw_stall0", 32'(bus.decode_ready), 32'd0);
        tick();
        chk("sw_stall1", 32'(bus.decode_ready), 32'd0);
        chk("sw_bubble", 32'(bus.alu_valid), 32'd0);
        wb(1'b1, 4'd5, 32'h99);
        settle();
        chk("sw_rdy2", 32'(bus.decode_ready), 32'd1);
        tick();
        wb(1'b0, 4'd0, 32'h0);
        chk("sw_a", bus.alu_data_a, 32'h99);
        chk("sw_b", bus.alu_data_b, 32'h99);
        chk("sw_writes", 32'(bus.alu_writes), 32'd0);

        // immediate masks a busy src_b (r1 still outstanding)
        drv(1'b1, 8'h66, 4'd11, 1'b0, 4'd2, 4'd1, 1'b0, 32'hA5);
        settle();
        chk("imm_off_stall", 32'(bus.decode_ready), 32'd0);
        bus.decode_use_imm = 1'b1;
        settle();
        chk("imm_rdy", 32'(bus.decode_ready), 32'd1);
        tick();
        chk("imm_b", bus.alu_data_b, 32'hA5);
        chk("imm_a", bus.alu_data_a, 32'h102);

        // reset in the middle of a stall with alu_valid set
        bus.alu_ready = 1'b0;
        drv(1'b1, 8'h77, 4'd12, 1'b0, 4'd1, 4'd0, 1'b0, 32'h0);
        tick();
        chk("pre_rst_v", 32'(bus.alu_valid), 32'd1);
        chk("pre_rst_rdy", 32'(bus.decode_ready), 32'd0);
        reset_n = 1'b0;
        settle();
        chk("mid_rst_v", 32'(bus.alu_valid), 32'd0);
        chk("mid_rst_a", bus.alu_data_a, 32'd0);
        chk("mid_rst_op", 32'(bus.alu_opcode), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        bus.alu_ready = 1'b1;
        drv(1'b1, 8'h88, 4'd9, 1'b1, 4'd1, 4'd6, 1'b0, 32'h0);
        settle();
        chk("post_rst_rdy", 32'(bus.decode_ready), 32'd1);
        tick();
        drv(1'b0, 8'h00, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 32'h0);
        chk("post_rst_v", 32'(bus.alu_valid), 32'd1);
        chk("post_rst_a", bus.alu_data_a, 32'h101);
        chk("post_rst_b", bus.alu_data_b, 32'h106);
        tick();
        chk("drain_v", 32'(bus.alu_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
